// File: rtl/sram_sp_masked_init.sv
// Single-port SRAM with per-lane write mask, READ_LATENCY-deep read pipe and an init sweep after reset or init_req.
// RW0_ready is low during the sweep and requests are dropped. `define SRAM_PARITY_EN adds per-lane even parity and RW0_perr.
module sram_sp_masked_init #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH = 12288,
  parameter int MASK_GRAN = 8,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int LANES = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] RW0_addr,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [LANES-1:0]      RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  output logic                  RW0_ready,
  output logic [DATA_WIDTH-1:0] RW0_rdata,
  output logic                  RW0_rvalid,
  output logic                  RW0_oor,
`ifdef SRAM_PARITY_EN
  output logic [LANES-1:0]      RW0_perr,
`endif
  input  logic                  init_req,
  output logic                  init_busy
);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    in_range, acc, rd_acc, wr_acc, sweep_we;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [READ_LATENCY-1:0] p_vld;
  logic [DATA_WIDTH-1:0]   p_dat [READ_LATENCY];

  assign in_range = {1'b0, RW0_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign acc      = RW0_en && RW0_ready;
  assign rd_acc   = acc && !RW0_wmode;
  assign wr_acc   = acc && RW0_wmode && in_range;
  assign sweep_we = (state == ST_INIT) && !reset;
  assign rd_word  = in_range ? mem[RW0_addr] : '0;

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
      RW0_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            init_busy <= 1'b0;
            RW0_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          // An access accepted in the same cycle wins over init_req.
          if (init_req && !acc) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
            RW0_ready <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] p_perr [READ_LATENCY];
  logic [LANES-1:0] rd_perr;

  function automatic logic [LANES-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
    lane_par = '0;
    for (int k = 0; k < LANES; k++) lane_par[k] = ^d[k*MASK_GRAN +: MASK_GRAN];
  endfunction

  assign rd_perr  = in_range ? (lane_par(rd_word) ^ par_mem[RW0_addr]) : '0;
  assign RW0_perr = p_vld[READ_LATENCY-1] ? p_perr[READ_LATENCY-1] : '0;

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) p_perr[i] <= '0;
    end else begin
      p_perr[0] <= rd_perr;
      for (int i = 1; i < READ_LATENCY; i++) p_perr[i] <= p_perr[i-1];
    end
  end
`endif

  // Array has no reset; the sweep is the only way contents get initialised.
  always_ff @(posedge RW0_clk) begin
    if (sweep_we) begin
      mem[cnt] <= INIT_VALUE;
`ifdef SRAM_PARITY_EN
      par_mem[cnt] <= lane_par(INIT_VALUE);
`endif
    end else if (wr_acc) begin
      for (int k = 0; k < LANES; k++) begin
        if (RW0_wmask[k]) begin
          mem[RW0_addr][k*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[k*MASK_GRAN +: MASK_GRAN];
`ifdef SRAM_PARITY_EN
          par_mem[RW0_addr][k] <= ^RW0_wdata[k*MASK_GRAN +: MASK_GRAN];
`endif
        end
      end
    end
  end

  // Data is sampled at accept; the final stage only loads on a valid so rdata holds between reads.
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      p_vld   <= '0;
      RW0_oor <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) p_dat[i] <= '0;
    end else begin
      RW0_oor  <= acc && !in_range;
      p_vld[0] <= rd_acc;
      if (rd_acc || READ_LATENCY > 1) p_dat[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        p_vld[i] <= p_vld[i-1];
        if (p_vld[i-1] || i < READ_LATENCY - 1) p_dat[i] <= p_dat[i-1];
      end
    end
  end

  assign RW0_rvalid = p_vld[READ_LATENCY-1];
  assign RW0_rdata  = p_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_sp_masked_init.sv
// Bench for sram_sp_masked_init: directed steps plus random traffic against an array/queue model,
// with a second READ_LATENCY=3 instance for pipeline timing and in-flight reset behaviour.
module tb_sram_sp_masked_init;
  localparam int DW = 32, AW = 14, DEPTH = 12288, G = 8, LANES = DW / G, RL = 1;
  localparam logic [DW-1:0] INITV = '0;

  logic            RW0_clk = 1'b0;
  logic            reset = 1'b1, reset3 = 1'b1;
  logic [AW-1:0]   addr = '0;
  logic            en = 1'b0, wmode = 1'b0, init_req = 1'b0;
  logic [LANES-1:0] wmask = '0;
  logic [DW-1:0]   wdata = '0;
  logic            ready, rvalid, oor, init_busy;
  logic [DW-1:0]   rdata;

  logic [5:0]      addr3 = '0;
  logic            en3 = 1'b0, wmode3 = 1'b0, init_req3 = 1'b0;
  logic [LANES-1:0] wmask3 = '0;
  logic [DW-1:0]   wdata3 = '0;
  logic            ready3, rvalid3, oor3, busy3;
  logic [DW-1:0]   rdata3;
`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] perr, perr3;
`endif

  always #5 RW0_clk = ~RW0_clk;

  sram_sp_masked_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MASK_GRAN(G),
                        .READ_LATENCY(RL), .INIT_VALUE(INITV)) dut (
    .RW0_clk(RW0_clk), .reset(reset), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_ready(ready), .RW0_rdata(rdata),
    .RW0_rvalid(rvalid), .RW0_oor(oor),
`ifdef SRAM_PARITY_EN
    .RW0_perr(perr),
`endif
    .init_req(init_req), .init_busy(init_busy));

  sram_sp_masked_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(6), .DEPTH(64), .MASK_GRAN(G),
                        .READ_LATENCY(3), .INIT_VALUE(INITV)) dut3 (
    .RW0_clk(RW0_clk), .reset(reset3), .RW0_addr(addr3), .RW0_en(en3), .RW0_wmode(wmode3),
    .RW0_wmask(wmask3), .RW0_wdata(wdata3), .RW0_ready(ready3), .RW0_rdata(rdata3),
    .RW0_rvalid(rvalid3), .RW0_oor(oor3),
`ifdef SRAM_PARITY_EN
    .RW0_perr(perr3),
`endif
    .init_req(init_req3), .init_busy(busy3));

  int errors = 0, checks = 0, cyc = 0;
  logic [DW-1:0]    model [DEPTH];
  logic [DW-1:0]    rq [$];
  logic [LANES-1:0] pq [$];
  int               dq [$];
  logic [DW-1:0]    last_rd = '0;
  logic             exp_oor = 1'b0, exp_ready = 1'b0;
  logic [LANES-1:0] inj = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the main instance: model the access being driven, advance, compare outputs.
  task automatic step();
    logic acc, inr;
    acc = en && exp_ready;
    inr = addr < AW'(DEPTH);
    exp_oor = acc && !inr;
    if (acc && !wmode) begin
      rq.push_back(inr ? model[addr] : '0);
      pq.push_back(inr ? inj : '0);
      dq.push_back(cyc + RL);
    end
    if (acc && wmode && inr)
      for (int k = 0; k < LANES; k++)
        if (wmask[k]) model[addr][k*G +: G] = wdata[k*G +: G];
    @(posedge RW0_clk); #1; cyc++;
    check("ready", ready, exp_ready);
    check("oor", oor, exp_oor);
    if (dq.size() > 0 && dq[0] == cyc) begin
      check("rvalid", rvalid, 1'b1);
      check("rdata", rdata, rq[0]);
`ifdef SRAM_PARITY_EN
      check("perr", perr, pq[0]);
`endif
      last_rd = rq[0];
      void'(rq.pop_front()); void'(pq.pop_front()); void'(dq.pop_front());
    end else begin
      check("rvalid_idle", rvalid, 1'b0);
      check("rdata_hold", rdata, last_rd);
`ifdef SRAM_PARITY_EN
      check("perr_idle", perr, '0);
`endif
    end
  endtask

  initial begin
    int n, bad;
    repeat (2) @(posedge RW0_clk);
    #1;
    check("rst_busy", init_busy, 1'b1);
    check("rst_ready", ready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_oor", oor, 1'b0);
    check("rst_rdata", rdata, '0);

    reset = 1'b0;
    n = 0; bad = 0;
    while (init_busy === 1'b1 && n < 20000) begin
      if (ready !== 1'b0) bad++;
      n++;
      @(posedge RW0_clk); #1;
    end
    check("sweep_len", n, DEPTH);
    check("sweep_ready_low", bad, 0);
    exp_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) model[a] = INITV;

    en = 1'b1; wmode = 1'b0; addr = 14'h2FFF; step();
    check("rd_last_word", rdata, 32'h0);

    wmode = 1'b1; addr = 14'h10; wdata = 32'hAABBCCDD; wmask = 4'hF; step();
    wdata = 32'h11223344; wmask = 4'h5; step();
    wmode = 1'b0; step();
    check("masked_rd", rdata, 32'hAA22CC44);
    wmode = 1'b1; wdata = 32'hFFFFFFFF; wmask = 4'h0; step();
    wmode = 1'b0; step();
    check("zero_mask_rd", rdata, 32'hAA22CC44);
    wmode = 1'b1; addr = 14'h11; wdata = 32'h5A5A5A5A; wmask = 4'hF; step();
    wmode = 1'b0; step();
    check("wr_then_rd", rdata, 32'h5A5A5A5A);

    wmode = 1'b1; addr = 14'h0; wdata = 32'h01020304; wmask = 4'hF; step();
    addr = 14'h3000; wdata = 32'hDEADBEEF; step();
    check("oor_wr_pulse", oor, 1'b1);
    wmode = 1'b0; step();
    check("oor_rd_pulse", oor, 1'b1);
    check("oor_rd_data", rdata, 32'h0);
    addr = 14'h0; step();
    check("oor_no_alias", rdata, 32'h01020304);

    init_req = 1'b1; addr = 14'h10; step();
    init_req = 1'b0;
    check("req_with_acc_busy", init_busy, 1'b0);
    en = 1'b0; step();

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      en = ($urandom_range(0, 3) != 0);
      wmode = 1'($urandom_range(0, 1));
      wmask = LANES'($urandom);
      wdata = $urandom;
      if (r < 7) addr = AW'($urandom_range(0, 31));
      else if (r == 7) addr = 14'h2FFF;
      else if (r == 8) addr = 14'h3000;
      else addr = AW'($urandom_range(12288, 16383));
      step();
    end
    en = 1'b0; step();

`ifdef SRAM_PARITY_EN
    en = 1'b1; wmode = 1'b1; addr = 14'h20; wdata = 32'hCAFEF00D; wmask = 4'hF; step();
    en = 1'b0;
    dut.par_mem[14'h20][2] <= ~dut.par_mem[14'h20][2];
    #1;
    inj = 4'b0100; en = 1'b1; wmode = 1'b0; step(); inj = '0;
    check("perr_lane2", perr, 4'b0100);
    check("perr_data", rdata, 32'hCAFEF00D);
    en = 1'b0; step();
`endif

    // READ_LATENCY=3 instance: pipelined timing and in-flight reset.
    reset3 = 1'b0;
    n = 0;
    while (busy3 === 1'b1 && n < 1000) begin
      n++;
      @(posedge RW0_clk); #1;
    end
    check("l3_sweep_len", n, 64);
    check("l3_ready", ready3, 1'b1);
    en3 = 1'b1; wmode3 = 1'b1; wmask3 = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      addr3 = 6'(i); wdata3 = 32'(i);
      @(posedge RW0_clk); #1;
    end
    wmode3 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 3) begin en3 = 1'b1; addr3 = 6'(k); end
      else en3 = 1'b0;
      @(posedge RW0_clk); #1;
      check("l3_rvalid", rvalid3, (k >= 3 && k <= 5));
      check("l3_rdata", rdata3, (k < 3) ? 0 : ((k > 5) ? 3 : k - 2));
    end
    en3 = 1'b1; addr3 = 6'd2;
    @(posedge RW0_clk); #1;
    en3 = 1'b0; reset3 = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      check("l3_inflight_rvalid", rvalid3, 1'b0);
      check("l3_inflight_rdata", rdata3, '0);
      @(posedge RW0_clk); #1;
    end

    // Re-init on request, interrupted by reset partway through.
    en = 1'b0; init_req = 1'b1;
    @(posedge RW0_clk); #1;
    init_req = 1'b0; exp_ready = 1'b0;
    check("req_busy", init_busy, 1'b1);
    check("req_ready", ready, 1'b0);
    repeat (99) @(posedge RW0_clk);
    #1;
    check("mid_sweep_busy", init_busy, 1'b1);
    reset = 1'b1; #1;
    check("rst2_busy", init_busy, 1'b1);
    check("rst2_ready", ready, 1'b0);
    check("rst2_rvalid", rvalid, 1'b0);
    check("rst2_rdata", rdata, '0);
    last_rd = '0;
    @(posedge RW0_clk); #1;
    reset = 1'b0;
    n = 0; bad = 0;
    while (init_busy === 1'b1 && n < 20000) begin
      if (ready !== 1'b0) bad++;
      n++;
      @(posedge RW0_clk); #1;
    end
    check("resweep_len", n, DEPTH);
    check("resweep_ready_low", bad, 0);
    exp_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) model[a] = INITV;
    en = 1'b1; wmode = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      addr = AW'(a);
      step();
    end
    en = 1'b0;
    repeat (RL) step();
    check("drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
